// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-style control unit:
// state encoding, ALU operation codes, opcode/funct constants and datapath select encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_IEXEC  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JALWB  = 4'd11,
    S_JREX   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1010;
  localparam logic [3:0] ALU_SLLV = 4'b1011;
  localparam logic [3:0] ALU_SRLV = 4'b1100;
  localparam logic [3:0] ALU_SRAV = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1110;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic       SRC_A_PC     = 1'b0;
  localparam logic       SRC_A_REG    = 1'b1;
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  function automatic logic is_imm_op(input logic [5:0] op);
    logic hit;
    case (op)
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
      OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI: hit = 1'b1;
      default:                           hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct to ALU operation decoder; valid flags a recognised operation.
// JR is deliberately not valid here: the FSM routes it before any ALU use.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       valid
);

  // Map R-type funct or I-type opcode onto an ALU operation
  always_comb begin
    alu_control = ALU_ADD;
    valid       = 1'b0;
    if (opcode == OP_RTYPE) begin
      valid = 1'b1;
      case (funct)
        FN_SLL:          alu_control = ALU_SLL;
        FN_SRL:          alu_control = ALU_SRL;
        FN_SRA:          alu_control = ALU_SRA;
        FN_SLLV:         alu_control = ALU_SLLV;
        FN_SRLV:         alu_control = ALU_SRLV;
        FN_SRAV:         alu_control = ALU_SRAV;
        FN_ADD, FN_ADDU: alu_control = ALU_ADD;
        FN_SUB, FN_SUBU: alu_control = ALU_SUB;
        FN_AND:          alu_control = ALU_AND;
        FN_OR:           alu_control = ALU_OR;
        FN_XOR:          alu_control = ALU_XOR;
        FN_NOR:          alu_control = ALU_NOR;
        FN_SLT:          alu_control = ALU_SLT;
        FN_SLTU:         alu_control = ALU_SLTU;
        default: begin
          alu_control = ALU_ADD;
          valid       = 1'b0;
        end
      endcase
    end else begin
      valid = 1'b1;
      case (opcode)
        OP_LW, OP_SW, OP_ADDI, OP_ADDIU: alu_control = ALU_ADD;
        OP_BEQ, OP_BNE:                  alu_control = ALU_SUB;
        OP_ANDI:                         alu_control = ALU_AND;
        OP_ORI:                          alu_control = ALU_OR;
        OP_XORI:                         alu_control = ALU_XOR;
        OP_SLTI:                         alu_control = ALU_SLT;
        OP_SLTIU:                        alu_control = ALU_SLTU;
        OP_LUI:                          alu_control = ALU_LUI;
        OP_J, OP_JAL:                    alu_control = ALU_ADD;
        default: begin
          alu_control = ALU_ADD;
          valid       = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: one registered state, combinational Moore output decode.
// Outputs stay quiet until the first clock edge after reset release, when fetching begins.
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] alu_control,
  output logic [3:0] state,
  output logic       illegal
);

  state_t     state_r;
  state_t     next_state_s;
  logic       run_r;
  logic       illegal_r;
  logic [3:0] dec_alu_s;
  logic       dec_valid_s;

  alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct       (funct),
    .alu_control (dec_alu_s),
    .valid       (dec_valid_s)
  );

  // State, run flag and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      run_r     <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (run_r) begin
        state_r <= next_state_s;
      end else begin
        state_r <= S_FETCH;
      end
      if (run_r && (state_r == S_DECODE) && (next_state_s == S_HALT)) begin
        illegal_r <= 1'b1;
      end else begin
        illegal_r <= illegal_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH:  next_state_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          next_state_s = S_MEMADR;
        end else if (opcode == OP_RTYPE) begin
          if (funct == FN_JR) begin
            next_state_s = S_JREX;
          end else if (dec_valid_s) begin
            next_state_s = S_REXEC;
          end else begin
            next_state_s = S_HALT;
          end
        end else if (is_imm_op(opcode)) begin
          next_state_s = S_IEXEC;
        end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
          next_state_s = S_BRANCH;
        end else if (opcode == OP_J) begin
          next_state_s = S_JUMP;
        end else if (opcode == OP_JAL) begin
          next_state_s = S_JALWB;
        end else begin
          next_state_s = S_HALT;
        end
      end
      S_MEMADR: next_state_s = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state_s = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state_s = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC,
      S_IEXEC:  next_state_s = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH,
      S_JUMP, S_JALWB, S_JREX: next_state_s = S_FETCH;
      S_HALT:   next_state_s = S_HALT;
      default:  next_state_s = S_HALT;
    endcase
  end

  // Output decode; everything is zero while reset is held or before the first fetch
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = REG_DST_RT;
    mem_to_reg  = M2R_ALUOUT;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_REG;
    pc_source   = PC_SRC_ALU;
    alu_control = ALU_ADD;
    if (run_r) begin
      case (state_r)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = SRC_B_IMM_SH;
        S_MEMADR: begin
          alu_src_a = SRC_A_REG;
          alu_src_b = SRC_B_IMM;
        end
        S_MEMRD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
        end
        S_REXEC: begin
          alu_src_a   = SRC_A_REG;
          alu_control = dec_alu_s;
        end
        S_IEXEC: begin
          alu_src_a   = SRC_A_REG;
          alu_src_b   = SRC_B_IMM;
          alu_control = dec_alu_s;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = (opcode == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
        end
        S_BRANCH: begin
          alu_src_a   = SRC_A_REG;
          alu_control = ALU_SUB;
          pc_source   = PC_SRC_ALUOUT;
          pc_write    = zero ^ (opcode == OP_BNE);
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PC_SRC_JUMP;
        end
        S_JALWB: begin
          pc_write   = 1'b1;
          pc_source  = PC_SRC_JUMP;
          reg_write  = 1'b1;
          reg_dst    = REG_DST_RA;
          mem_to_reg = M2R_PC;
        end
        S_JREX: begin
          pc_write  = 1'b1;
          pc_source = PC_SRC_RS;
        end
        S_HALT:  pc_write = 1'b0;
        default: pc_write = 1'b0;
      endcase
    end else begin
      pc_write = 1'b0;
    end
  end

  assign state   = state_r;
  assign illegal = illegal_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of instructions scored through a queue,
// plus hand sequences for memory stalls, illegal instructions and reset mid-access.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic       alu_src_a, illegal;
  logic [3:0] alu_control, state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_control(alu_control),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         cyc;
    logic [3:0] c3_alu;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] m2r;
    int         rw_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input string name, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input int cyc, input logic [3:0] c3,
                      input logic pcw, input logic [1:0] pcs, input logic rw,
                      input logic [1:0] rd, input logic [1:0] m2r, input int rwc);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.z = z; v.cyc = cyc; v.c3_alu = c3;
    v.pcw = pcw; v.pcs = pcs; v.rw = rw; v.rd = rd; v.m2r = m2r; v.rw_cnt = rwc;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run from the current negedge until the FSM is back in FETCH (or HALT), bounded
  task automatic run_instr(output int cyc, output logic [3:0] c3, output logic pcw,
                           output logic [1:0] pcs, output logic rw, output logic [1:0] rd,
                           output logic [1:0] m2r, output int rwc);
    cyc = 0; rwc = 0; c3 = 4'hf;
    pcw = 1'b0; pcs = 2'b00; rw = 1'b0; rd = 2'b00; m2r = 2'b00;
    for (int k = 0; k < 40; k++) begin
      #1;
      cyc++;
      if (cyc == 3) c3 = alu_control;
      pcw = pc_write; pcs = pc_source; rw = reg_write; rd = reg_dst; m2r = mem_to_reg;
      if (reg_write === 1'b1) rwc++;
      step();
      if (state == 4'd0 || state == 4'd13) break;
    end
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    check("rst.state", state, 4'd0);
    check("rst.illegal", illegal, 1'b0);
    check("rst.enables", {pc_write, ir_write, mem_read, mem_write, reg_write, iord}, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step();
  endtask

  int         cyc, rwc, irc, irl;
  logic [3:0] c3;
  logic       pcw, rw;
  logic [1:0] pcs, rd, m2r;
  vec_t       e;

  initial begin
    opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

    addv("lw",     6'b100011, 6'b000000, 1'b0, 5, 4'b0000, 1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 1);
    addv("sw",     6'b101011, 6'b000000, 1'b0, 4, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 0);
    addv("slt",    6'b000000, 6'b101010, 1'b0, 4, 4'b1000, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1);
    addv("add",    6'b000000, 6'b100000, 1'b0, 4, 4'b0000, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1);
    addv("sub",    6'b000000, 6'b100010, 1'b0, 4, 4'b0001, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1);
    addv("nor",    6'b000000, 6'b100111, 1'b0, 4, 4'b1010, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1);
    addv("srl",    6'b000000, 6'b000010, 1'b0, 4, 4'b0110, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1);
    addv("srav",   6'b000000, 6'b000111, 1'b0, 4, 4'b1101, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 1);
    addv("addi",   6'b001000, 6'b000000, 1'b0, 4, 4'b0000, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1);
    addv("ori",    6'b001101, 6'b000000, 1'b0, 4, 4'b0011, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1);
    addv("lui",    6'b001111, 6'b000000, 1'b0, 4, 4'b1110, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1);
    addv("sltiu",  6'b001011, 6'b000000, 1'b0, 4, 4'b1001, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1);
    addv("beq_z1", 6'b000100, 6'b000000, 1'b1, 3, 4'b0001, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 0);
    addv("beq_z0", 6'b000100, 6'b000000, 1'b0, 3, 4'b0001, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 0);
    addv("bne_z1", 6'b000101, 6'b000000, 1'b1, 3, 4'b0001, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 0);
    addv("bne_z0", 6'b000101, 6'b000000, 1'b0, 3, 4'b0001, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 0);
    addv("j",      6'b000010, 6'b000000, 1'b0, 3, 4'b0000, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 0);
    addv("jal",    6'b000011, 6'b000000, 1'b0, 3, 4'b0000, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10, 1);
    addv("jr",     6'b000000, 6'b001000, 1'b0, 3, 4'b0000, 1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 0);

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("reset.state", state, 4'd0);
    check("reset.illegal", illegal, 1'b0);
    check("reset.enables", {pc_write, ir_write, iord, mem_read, mem_write, reg_write}, 6'd0);
    check("reset.selects", {reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source}, 9'd0);
    check("reset.alu", alu_control, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    #1;
    check("first_fetch.state", state, 4'd0);
    check("first_fetch.mem_read", mem_read, 1'b1);
    check("first_fetch.alu_src_b", alu_src_b, 2'b01);

    // Table-driven instructions, mem_ready tied high
    foreach (vecs[i]) begin
      opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z;
      sb.push_back(vecs[i]);
      run_instr(cyc, c3, pcw, pcs, rw, rd, m2r, rwc);
      e = sb.pop_front();
      check({e.name, ".cycles"}, cyc, e.cyc);
      check({e.name, ".alu_c3"}, c3, e.c3_alu);
      check({e.name, ".pc_write"}, pcw, e.pcw);
      check({e.name, ".pc_source"}, pcs, e.pcs);
      check({e.name, ".reg_write"}, rw, e.rw);
      check({e.name, ".reg_dst"}, rd, e.rd);
      check({e.name, ".mem_to_reg"}, m2r, e.m2r);
      check({e.name, ".rw_count"}, rwc, e.rw_cnt);
      check({e.name, ".end_state"}, state, 4'd0);
    end

    // Fetch stalled three cycles, then an ADDI completes
    opcode = 6'b001000; funct = 6'd0; irc = 0; irl = 0;
    for (int c = 1; c <= 4; c++) begin
      mem_ready = (c == 4);
      #1;
      check("stall.state", state, 4'd0);
      check("stall.mem_read", mem_read, 1'b1);
      check("stall.iord", iord, 1'b0);
      check("stall.pc_write", pc_write, (c == 4));
      if (ir_write === 1'b1) begin irc++; irl = c; end
      step();
    end
    check("stall.ir_count", irc, 1);
    check("stall.ir_cycle", irl, 4);
    check("stall.decode", state, 4'd1);
    mem_ready = 1'b1;
    run_instr(cyc, c3, pcw, pcs, rw, rd, m2r, rwc);
    check("stall.rest_cycles", cyc, 3);

    // LW with MEMRD stalled two cycles
    begin
      logic [3:0] st_e [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
      logic       mr_e [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       io_e [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       rdy  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      opcode = 6'b100011;
      for (int c = 0; c < 7; c++) begin
        mem_ready = rdy[c];
        #1;
        check($sformatf("lwstall.state[%0d]", c), state, st_e[c]);
        check($sformatf("lwstall.mem_read[%0d]", c), mem_read, mr_e[c]);
        check($sformatf("lwstall.iord[%0d]", c), iord, io_e[c]);
        if (c == 1) check("lwstall.decode_srcb", {alu_src_a, alu_src_b}, 3'b011);
        if (c == 2) check("lwstall.memadr_src", {alu_src_a, alu_src_b}, 3'b110);
        step();
      end
      check("lwstall.end", state, 4'd0);
      mem_ready = 1'b1;
    end

    // Reset asserted in the middle of a stalled store
    opcode = 6'b101011;
    step(); step(); mem_ready = 1'b0; step();
    #1;
    check("memwr.state", state, 4'd5);
    check("memwr.strobe", {mem_write, iord}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    check("memwr_rst.state", state, 4'd0);
    check("memwr_rst.outputs", {mem_write, iord, mem_read, pc_write, ir_write, reg_write}, 6'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    step();
    #1;
    check("restart.state", state, 4'd0);
    check("restart.mem_read", mem_read, 1'b1);
    run_instr(cyc, c3, pcw, pcs, rw, rd, m2r, rwc);
    check("restart.sw_cycles", cyc, 4);

    // Unknown opcode halts with illegal set
    opcode = 6'b111111;
    check("ill_op.pre_illegal", illegal, 1'b0);
    step(); step();
    for (int c = 0; c < 3; c++) begin
      #1;
      check("ill_op.state", state, 4'd13);
      check("ill_op.illegal", illegal, 1'b1);
      check("ill_op.enables", {pc_write, ir_write, mem_read, mem_write, reg_write}, 5'd0);
      step();
    end
    reset_pulse();

    // R-type with unknown funct halts with illegal set
    opcode = 6'b000000; funct = 6'b111111;
    step(); step();
    #1;
    check("ill_fn.state", state, 4'd13);
    check("ill_fn.illegal", illegal, 1'b1);
    check("ill_fn.reg_write", reg_write, 1'b0);
    reset_pulse();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
